// File: rtl/turbo_pkg.sv
// Shared turbo interleaver constants: PB size codes, pair counts and
// interleave steps. The write side and pb_encoder use the same values.
package turbo_pkg;

    // Bit-pair index width that covers the largest PB (2080 pairs).
    localparam int unsigned TURBO_AW = 12;

    typedef enum logic [1:0] {
        PB16    = 2'b00,
        PB136   = 2'b01,
        PB520   = 2'b10,
        PB_RSVD = 2'b11
    } pb_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

    localparam logic [TURBO_AW-1:0] LEN_PB16  = TURBO_AW'(64);
    localparam logic [TURBO_AW-1:0] LEN_PB136 = TURBO_AW'(544);
    localparam logic [TURBO_AW-1:0] LEN_PB520 = TURBO_AW'(2080);

    // Each step is coprime with its length, so k*S mod L visits every index once.
    localparam logic [TURBO_AW-1:0] STEP_PB16  = TURBO_AW'(31);
    localparam logic [TURBO_AW-1:0] STEP_PB136 = TURBO_AW'(33);
    localparam logic [TURBO_AW-1:0] STEP_PB520 = TURBO_AW'(31);

    function automatic logic [TURBO_AW-1:0] pb_len_lut(input pb_size_e sz);
        case (sz)
            PB16:    return LEN_PB16;
            PB136:   return LEN_PB136;
            PB520:   return LEN_PB520;
            default: return '0;
        endcase
    endfunction

    function automatic logic [TURBO_AW-1:0] pb_step_lut(input pb_size_e sz);
        case (sz)
            PB16:    return STEP_PB16;
            PB136:   return STEP_PB136;
            PB520:   return STEP_PB520;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/turbo_mod_step.sv
// Combinational modular step: nxt = (a + step) mod len, with a, step < len.
// Kept standalone so the write/interleave side can reuse it.
module turbo_mod_step
    import turbo_pkg::*;
#(
    parameter int unsigned AW = TURBO_AW
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] step,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] nxt
);

    logic [AW:0] sum;

    // One extra bit holds the carry; a single conditional subtract folds it back.
    always_comb begin
        sum = {1'b0, a} + {1'b0, step};
        if (sum >= {1'b0, len}) begin
            sum = sum - {1'b0, len};
        end
        nxt = sum[AW-1:0];
    end

endmodule

// File: rtl/turbo_rd_addr.sv
// Read-side address generator for the turbo interleaver pair RAM.
// Issues a(k) = k*S mod L for k = 0..L-1 under rd_ready back-pressure and
// delays the read enable by the RAM latency to flag output data valid.
module turbo_rd_addr
    import turbo_pkg::*;
#(
    parameter int unsigned AW      = TURBO_AW,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [1:0]    pb_size,
    input  logic          rd_ready,
    output logic [AW-1:0] raddr,
    output logic          ren,
    output logic [AW-1:0] pb_len,
    output logic          busy,
    output logic          dout_vld,
    output logic          last,
    output logic          done
);

    localparam int unsigned DW = $clog2(RAM_LAT + 1);

    rd_state_e          state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      k_q, k_d;
    logic [AW-1:0]      len_q, len_d;
    logic [AW-1:0]      step_q, step_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [RAM_LAT-1:0] vld_q, vld_d;
    logic [RAM_LAT-1:0] lst_q, lst_d;

    logic [AW-1:0]      a_nxt;
    logic               k_last;
    pb_size_e           size_e;

    assign size_e = pb_size_e'(pb_size);
    assign ren    = rd_ready && (state_q == ST_RUN);
    assign k_last = (k_q == (len_q - AW'(1)));

    turbo_mod_step #(
        .AW (AW)
    ) u_step (
        .a    (a_q),
        .step (step_q),
        .len  (len_q),
        .nxt  (a_nxt)
    );

    // Next-state logic for the readout FSM, index counter and address.
    // The address is not advanced on the final pair so raddr keeps showing
    // the last issued index until the next PB starts.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        k_d     = k_q;
        len_d   = len_q;
        step_d  = step_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (size_e != PB_RSVD)) begin
                    state_d = ST_RUN;
                    len_d   = AW'(pb_len_lut(size_e));
                    step_d  = AW'(pb_step_lut(size_e));
                    a_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (ren) begin
                    if (k_last) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        a_d = a_nxt;
                        k_d = k_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DW'(RAM_LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Valid/last delay line matching the RAM read latency.
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = ren;
        lst_d[0] = ren && k_last;
        for (int unsigned i = 1; i < RAM_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    // FSM state and registered status outputs; reset aborts any readout.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            step_q  <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            k_q     <= k_d;
            len_q   <= len_d;
            step_q  <= step_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Delay line registers; cleared by reset so in-flight data is dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    assign raddr    = a_q;
    assign pb_len   = len_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dout_vld = vld_q[RAM_LAT-1];
    assign last     = lst_q[RAM_LAT-1];

endmodule

// File: tb/tb_turbo_rd_addr.sv
// Directed bench for turbo_rd_addr: reset values, reserved size, the three
// PB sizes with and without back-pressure, restart rejection and mid-run reset.
module tb_turbo_rd_addr;

    localparam int unsigned AW      = 12;
    localparam int unsigned RAM_LAT = 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [1:0]    pb_size;
    logic          rd_ready;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [AW-1:0] pb_len;
    logic          busy;
    logic          dout_vld;
    logic          last;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turbo_rd_addr #(
        .AW      (AW),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .pb_size  (pb_size),
        .rd_ready (rd_ready),
        .raddr    (raddr),
        .ren      (ren),
        .pb_len   (pb_len),
        .busy     (busy),
        .dout_vld (dout_vld),
        .last     (last),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_raddr"},    32'(raddr),    0);
        chk({tag, "_ren"},      32'(ren),      0);
        chk({tag, "_pb_len"},   32'(pb_len),   0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_dout_vld"}, 32'(dout_vld), 0);
        chk({tag, "_last"},     32'(last),     0);
        chk({tag, "_done"},     32'(done),     0);
    endtask

    // One full PB readout; expected addresses come from k*S mod L directly.
    task automatic run_pb(input string tag, input logic [1:0] sz, input int unsigned len,
                          input int unsigned stp, input bit toggle, input bit restart,
                          input int unsigned final_addr);
        bit          seen [4096];
        int unsigned k = 0, nvld = 0, nlast = 0, last_at = 0;
        int unsigned addr_bad = 0, dup = 0, vld_bad = 0, missing = 0;
        int unsigned nbusy = 0, last_ren = 0, done_at = 0;
        int unsigned budget;
        bit          got_done = 1'b0;
        logic        prev_ren = 1'b0;

        budget = 2 * len + 20;
        @(negedge clk);
        start    = 1'b1;
        pb_size  = sz;
        rd_ready = 1'b0;
        for (int unsigned cyc = 0; cyc < budget && !got_done; cyc++) begin
            @(negedge clk);
            start    = restart && (cyc == 5);
            pb_size  = (restart && (cyc == 5)) ? 2'b10 : sz;
            rd_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (busy === 1'b1) nbusy++;
            if (dout_vld !== prev_ren) vld_bad++;
            prev_ren = ren;
            if (ren === 1'b1) begin
                if (32'(raddr) != (k * stp) % len) addr_bad++;
                if (seen[raddr]) dup++;
                seen[raddr] = 1'b1;
                k++;
                last_ren = cyc;
            end
            if (dout_vld === 1'b1) nvld++;
            if (last === 1'b1) begin
                nlast++;
                last_at = nvld;
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_at  = cyc;
            end
        end
        for (int unsigned i = 0; i < len; i++) begin
            if (!seen[i]) missing++;
        end
        chk({tag, "_done_seen"},  32'(got_done), 1);
        chk({tag, "_ren_count"},  k, len);
        chk({tag, "_vld_count"},  nvld, len);
        chk({tag, "_last_count"}, nlast, 1);
        chk({tag, "_last_pos"},   last_at, len);
        chk({tag, "_addr_bad"},   addr_bad, 0);
        chk({tag, "_dup"},        dup, 0);
        chk({tag, "_missing"},    missing, 0);
        chk({tag, "_vld_align"},  vld_bad, 0);
        chk({tag, "_done_lat"},   done_at - last_ren, RAM_LAT + 1);
        chk({tag, "_busy_width"}, nbusy, toggle ? 2 * len : len + RAM_LAT);
        chk({tag, "_final_addr"}, 32'(raddr), final_addr);
        chk({tag, "_pb_len"},     32'(pb_len), len);
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_addr_hold"},  32'(raddr), final_addr);
    endtask

    initial begin
        int unsigned bad;
        int unsigned nr;

        n_rst    = 1'b0;
        start    = 1'b0;
        pb_size  = 2'b00;
        rd_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk_all_zero("post_reset");

        // Reserved size code must not start a readout.
        @(negedge clk);
        start    = 1'b1;
        pb_size  = 2'b11;
        rd_ready = 1'b1;
        bad = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (ren !== 1'b0 || busy !== 1'b0 || dout_vld !== 1'b0) bad++;
        end
        chk("rsvd_no_activity", bad, 0);
        chk("rsvd_pb_len", 32'(pb_len), 0);

        // PB16 with a second start mid-run that must be ignored.
        run_pb("pb16_restart", 2'b00, 64, 31, 1'b0, 1'b1, 33);

        // PB136 with rd_ready toggling every cycle.
        run_pb("pb136_toggle", 2'b01, 544, 33, 1'b1, 1'b0, 511);

        // PB520 at full rate.
        run_pb("pb520", 2'b10, 2080, 31, 1'b0, 1'b0, 2049);

        // Reset mid-run after 100 reads of a PB520.
        @(negedge clk);
        start    = 1'b1;
        pb_size  = 2'b10;
        rd_ready = 1'b1;
        nr = 0;
        for (int unsigned c = 0; c < 200 && nr < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (ren === 1'b1) nr++;
        end
        chk("mid_reads", nr, 100);
        chk("mid_busy", 32'(busy), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || last !== 1'b0 || dout_vld !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("after_abort_quiet", bad, 0);

        // Clean PB16 after the abort.
        run_pb("pb16_clean", 2'b00, 64, 31, 1'b0, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
